// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: round-robin sharing of one registered NAND unit among N_REQ requesters
module nand_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a,
  input  logic [N_REQ*WIDTH-1:0] b,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       s,
  output logic [ID_W-1:0]        s_id,
  output logic                   s_valid,
  input  logic                   s_ready,
  output logic                   busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr, id_q, win;
  logic [WIDTH-1:0] a_q, b_q;
  logic             found;
  int               idx;
  assign busy = state != IDLE;
  // first requester at or above rr_ptr, wrapping
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = ID_W'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      s       <= '0;
      s_id    <= '0;
      s_valid <= 1'b0;
      rr_ptr  <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: if (found) begin
          a_q    <= a[int'(win)*WIDTH +: WIDTH];
          b_q    <= b[int'(win)*WIDTH +: WIDTH];
          id_q   <= win;
          gnt    <= N_REQ'(1) << win;
          rr_ptr <= ID_W'((int'(win) + 1) % N_REQ);
          state  <= CALC;
        end
        CALC: begin
          s       <= ~(a_q & b_q);
          s_id    <= id_q;
          s_valid <= 1'b1;
          state   <= RESP;
        end
        RESP: if (s_ready) begin
          s_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand_share_arbiter.sv
// tb_nand_share_arbiter: directed plan scenarios plus random traffic against a transaction-level model
module tb_nand_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0, reset = 1'b1, s_ready = 1'b0;
  logic [N-1:0]   req = '0, gnt;
  logic [N*W-1:0] a = '0, b = '0;
  logic [W-1:0]   s;
  logic [1:0]     s_id;
  logic           s_valid, busy;
  int n_cmp = 0, n_err = 0;
  // reference: an operation is "owned" from grant until the consumer takes it
  int           m_ptr = 0, m_age = 0, m_owner = -1;
  logic [W-1:0] m_a, m_b, m_s = '0;
  int           m_sid = 0;
  logic [N-1:0] m_gnt = '0;
  logic         m_valid = 1'b0;

  nand_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .gnt(gnt), .s(s),
    .s_id(s_id), .s_valid(s_valid), .s_ready(s_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] rot;
    rot = {r, r} >> p;
    for (int k = 0; k < N; k++) if (rot[k]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    m_gnt = '0;
    if (reset) begin
      m_ptr = 0; m_age = 0; m_owner = -1; m_s = '0; m_sid = 0; m_valid = 1'b0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = pick(req, m_ptr);
        m_a = a[m_owner*W +: W];
        m_b = b[m_owner*W +: W];
        m_gnt[m_owner] = 1'b1;
        m_ptr = (m_owner + 1) % N;
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_s = ~(m_a & m_b);
      m_sid = m_owner;
      m_valid = 1'b1;
      m_age = 2;
    end else if (s_ready) begin
      m_valid = 1'b0;
      m_owner = -1;
    end
  end

  always @(negedge clk) begin
    check("gnt", gnt, m_gnt);
    check("s_valid", s_valid, m_valid);
    check("busy", busy, m_owner >= 0);
    check("s", s, m_s);
    check("s_id", s_id, m_sid);
  end

  task automatic wait_gnt();
    int n = 0;
    while (gnt == 0 && n < 12) begin @(negedge clk); n++; end
    if (gnt == 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!s_valid && n < 12) begin @(negedge clk); n++; end
    if (!s_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    req = '0; s_ready = 1'b1;
    while (busy && n < 12) begin @(negedge clk); n++; end
    if (busy) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_outs", {gnt, s, s_id, s_valid, busy}, 0);
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq [$];
    logic [W-1:0] held;
    @(negedge clk);
    do_reset();
    // 1: basic operation
    req = 4'b0001; a[7:0] = 8'hFF; b[7:0] = 8'h0F; s_ready = 1'b1;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0001);
    req = '0;
    @(negedge clk);
    check("t1_s", {s_valid, s, s_id}, {1'b1, 8'hF0, 2'd0});
    @(negedge clk);
    check("t1_busy", busy, 0);
    // 2: full round robin
    do_reset();
    req = '1; a = $urandom; b = $urandom;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (gnt != 0) seq.push_back(gnt);
    end
    check("t2_count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) check("t2_order", seq[i], 1 << (i % 4));
    drain();
    // 3: wrap from rr_ptr=3
    do_reset();
    req = 4'b0100;
    wait_gnt();
    req = '0;
    drain();
    req = 4'b1001; a[31:24] = 8'hAA; b[31:24] = 8'hCC;
    wait_gnt();
    check("t3_gnt", gnt, 4'b1000);
    req = 4'b0001;
    wait_valid();
    check("t3_s", {s, s_id}, {8'h77, 2'd3});
    @(negedge clk);
    wait_gnt();
    check("t3_wrap", gnt, 4'b0001);
    drain();
    // 4: backpressure
    do_reset();
    s_ready = 1'b0; req = 4'b0001;
    wait_gnt();
    req = 4'b0110;
    wait_valid();
    held = s;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold", {gnt, s_valid, s}, {4'b0000, 1'b1, held});
    end
    s_ready = 1'b1;
    @(negedge clk);
    wait_gnt();
    check("t4_next", gnt, 4'b0010);
    drain();
    // 5: operands captured at grant
    do_reset();
    req = 4'b0010; a[15:8] = 8'h00; b[15:8] = 8'hFF;
    wait_gnt();
    req = '0; a[15:8] = 8'hFF;
    wait_valid();
    check("t5_s", s, 8'hFF);
    drain();
    // 6: reset in CALC and in RESP
    req = 4'b0001; s_ready = 1'b0;
    wait_gnt();
    req = '0;
    do_reset();
    req = 4'b0001;
    wait_valid();
    req = '0;
    do_reset();
    req = 4'b0101;
    @(negedge clk);
    check("t6_ptr0", gnt, 4'b0001);
    drain();
    // random traffic honouring the hold-until-grant protocol
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      s_ready = $urandom_range(0, 2) != 0;
      for (int i = 0; i < N; i++)
        req[i] = (req[i] && !gnt[i]) ? 1'b1 : ($urandom_range(0, 3) == 0);
      a = {$urandom}; b = {$urandom};
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
